dutsig_vec_queue: RTL and testbench

//  Next-generation DUT signal driver. WIDTH-bit vector register fed by a DEPTH-entry staging queue.

---
 rtl/dutsig_vec_queue.sv | 129 ++++++++++++
 tb/tb_dutsig_vec_queue.sv | 256 +++++++++++++++++++++++++
 2 files changed

// File: rtl/dutsig_vec_queue.sv
// DUT signal driver: WIDTH-bit registered vector Q fed from a DEPTH-entry FIFO staging queue; optional self-timed transfer under `DUTSIG_AUTO_XFER_EN.
// Latency: a vector pushed at edge k can reach Q at edge k+1 when TRANSFER (or an auto strobe) is high in cycle k+1; all outputs are registered.
// Backpressure: none; a LOAD into a full queue without a pop is dropped and sets OVERFLOW, a pop from an empty queue holds Q and sets UNDERFLOW.
module dutsig_vec_queue #(
    parameter int               WIDTH    = 8,
    parameter int               DEPTH    = 4,
    parameter logic [WIDTH-1:0] RESET_Q  = '0,
    parameter int               PERIOD_W = 16
) (
    input  logic                         CLK,
    input  logic                         RST_N,
    input  logic                         CLR,
    input  logic                         LOAD,
    input  logic                         TRANSFER,
    input  logic [WIDTH-1:0]             D,
`ifdef DUTSIG_AUTO_XFER_EN
    input  logic                         AUTO_EN,
    input  logic [PERIOD_W-1:0]          PERIOD,
`endif
    output logic [WIDTH-1:0]             Q,
    output logic [$clog2(DEPTH+1)-1:0]   COUNT,
    output logic                         FULL,
    output logic                         EMPTY,
    output logic                         OVERFLOW,
    output logic                         UNDERFLOW
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH+1);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    head;
    logic [AW-1:0]    tail;
    logic [CW-1:0]    count;
    logic [WIDTH-1:0] q_r;
    logic             ovf_r;
    logic             udf_r;

    logic             full;
    logic             empty;
    logic             auto_strobe;
    logic             xfer;
    logic             do_push;
    logic             do_pop;

    assign full  = (count == CW'(DEPTH));
    assign empty = (count == '0);

`ifdef DUTSIG_AUTO_XFER_EN
    logic [PERIOD_W-1:0] auto_cnt;
    logic [PERIOD_W-1:0] period_last;

    // PERIOD of 0 behaves as 1, i.e. a strobe every enabled cycle.
    assign period_last = (PERIOD == '0) ? '0 : PERIOD - PERIOD_W'(1);
    // >= rather than == so a PERIOD lowered below the running count strobes at the next compare instead of waiting for a full counter wrap.
    assign auto_strobe = AUTO_EN && (auto_cnt >= period_last);

    // Free-running period counter; held at 0 while disabled so the first strobe lands P cycles after enable.
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            auto_cnt <= '0;
        end else if (CLR || !AUTO_EN || auto_strobe) begin
            auto_cnt <= '0;
        end else begin
            auto_cnt <= auto_cnt + PERIOD_W'(1);
        end
    end
`else
    assign auto_strobe = 1'b0;
`endif

    // A manual and an auto request in the same cycle merge into a single pop.
    assign xfer    = TRANSFER | auto_strobe;
    assign do_pop  = !CLR && xfer && !empty;
    // At FULL a coincident pop frees the slot being written, so the push is still legal.
    assign do_push = !CLR && LOAD && (!full || do_pop);

    // Staging storage; contents are don't-care until written, so no reset is needed.
    always_ff @(posedge CLK) begin
        if (do_push) begin
            mem[tail] <= D;
        end
    end

    // Queue pointers, occupancy, output vector and sticky error flags.
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            head  <= '0;
            tail  <= '0;
            count <= '0;
            q_r   <= RESET_Q;
            ovf_r <= 1'b0;
            udf_r <= 1'b0;
        end else if (CLR) begin
            head  <= '0;
            tail  <= '0;
            count <= '0;
            ovf_r <= 1'b0;
            udf_r <= 1'b0;
        end else begin
            if (do_push) begin
                tail <= tail + AW'(1);
            end
            if (do_pop) begin
                head <= head + AW'(1);
                q_r  <= mem[head];
            end
            if (do_push && !do_pop) begin
                count <= count + CW'(1);
            end else if (do_pop && !do_push) begin
                count <= count - CW'(1);
            end
            if (LOAD && full && !xfer) begin
                ovf_r <= 1'b1;
            end
            if (xfer && empty) begin
                udf_r <= 1'b1;
            end
        end
    end

    assign Q         = q_r;
    assign COUNT     = count;
    assign FULL      = full;
    assign EMPTY     = empty;
    assign OVERFLOW  = ovf_r;
    assign UNDERFLOW = udf_r;

endmodule

// File: tb/tb_dutsig_vec_queue.sv
// Bench for dutsig_vec_queue: directed vector table, async reset sequences, randomized run against a queue model.
// Latency: outputs sampled 1 time unit after each rising edge.
// Backpressure: not applicable; bench drives every input each cycle.
module tb_dutsig_vec_queue;

    localparam int DEPTH = 4;

    logic        CLK;
    logic        RST_N;
    logic        CLR;
    logic        LOAD;
    logic        TRANSFER;
    logic [7:0]  D;
    logic [7:0]  Q;
    logic [2:0]  COUNT;
    logic        FULL;
    logic        EMPTY;
    logic        OVERFLOW;
    logic        UNDERFLOW;
`ifdef DUTSIG_AUTO_XFER_EN
    logic        AUTO_EN;
    logic [15:0] PERIOD;
`endif

    int n_chk;
    int n_fail;

    dutsig_vec_queue #(
        .WIDTH   (8),
        .DEPTH   (DEPTH),
        .RESET_Q (8'hA5),
        .PERIOD_W(16)
    ) dut (
        .CLK      (CLK),
        .RST_N    (RST_N),
        .CLR      (CLR),
        .LOAD     (LOAD),
        .TRANSFER (TRANSFER),
        .D        (D),
`ifdef DUTSIG_AUTO_XFER_EN
        .AUTO_EN  (AUTO_EN),
        .PERIOD   (PERIOD),
`endif
        .Q        (Q),
        .COUNT    (COUNT),
        .FULL     (FULL),
        .EMPTY    (EMPTY),
        .OVERFLOW (OVERFLOW),
        .UNDERFLOW(UNDERFLOW)
    );

    initial begin
        CLK = 1'b0;
        forever #5 CLK = ~CLK;
    end

    typedef struct {
        logic       clr;
        logic       load;
        logic       xfer;
        logic [7:0] d;
        logic [7:0] q;
        int         cnt;
        logic       ovf;
        logic       udf;
    } vec_t;

    vec_t tbl[$];

    // Behavioural reference: plain FIFO of staged vectors plus the last popped value.
    logic [7:0] mq[$];
    logic [7:0] m_q;
    logic       m_ovf;
    logic       m_udf;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic chk_all(input string tag, input logic [7:0] q, input int cnt,
                           input logic ovf, input logic udf);
        chk({tag, " Q"},         32'(Q),         32'(q));
        chk({tag, " COUNT"},     32'(COUNT),     32'(cnt));
        chk({tag, " FULL"},      32'(FULL),      32'(cnt == DEPTH));
        chk({tag, " EMPTY"},     32'(EMPTY),     32'(cnt == 0));
        chk({tag, " OVERFLOW"},  32'(OVERFLOW),  32'(ovf));
        chk({tag, " UNDERFLOW"}, 32'(UNDERFLOW), 32'(udf));
    endtask

    task automatic step(input logic clr, input logic load, input logic xfer, input logic [7:0] d);
        CLR      = clr;
        LOAD     = load;
        TRANSFER = xfer;
        D        = d;
        @(posedge CLK);
        #1;
        CLR      = 1'b0;
        LOAD     = 1'b0;
        TRANSFER = 1'b0;
    endtask

    task automatic model_step(input logic clr, input logic load, input logic xfer, input logic [7:0] d);
        int had;
        if (clr) begin
            mq.delete();
            m_ovf = 1'b0;
            m_udf = 1'b0;
        end else begin
            had = mq.size();
            if (xfer) begin
                if (had > 0) m_q = mq.pop_front();
                else         m_udf = 1'b1;
            end
            if (load) begin
                if (had < DEPTH || xfer) mq.push_back(d);
                else                     m_ovf = 1'b1;
            end
        end
    endtask

    function automatic vec_t mk(input logic clr, input logic load, input logic xfer, input logic [7:0] d,
                                input logic [7:0] q, input int cnt, input logic ovf, input logic udf);
        vec_t v;
        v.clr = clr; v.load = load; v.xfer = xfer; v.d = d;
        v.q = q; v.cnt = cnt; v.ovf = ovf; v.udf = udf;
        return v;
    endfunction

    task automatic pulse_reset();
        @(posedge CLK);
        #2 RST_N = 1'b0;
        #1;
    endtask

    task automatic release_reset();
        @(posedge CLK);
        #1 RST_N = 1'b1;
    endtask

    initial begin
        logic c, l, x;
        logic [7:0] d;
        n_chk = 0;
        n_fail = 0;
        RST_N = 1'b1;
        CLR = 1'b0; LOAD = 1'b0; TRANSFER = 1'b0; D = 8'h00;
`ifdef DUTSIG_AUTO_XFER_EN
        AUTO_EN = 1'b0;
        PERIOD  = 16'd3;
`endif

        // Reset asserted mid-cycle must take effect without a clock edge.
        pulse_reset();
        chk_all("reset", 8'hA5, 0, 1'b0, 1'b0);
        release_reset();

        // clr, load, xfer, d  ->  q, count, ovf, udf
        tbl.push_back(mk(0,0,1,8'h00, 8'hA5,0,0,1));
        tbl.push_back(mk(0,1,0,8'h11, 8'hA5,1,0,1));
        tbl.push_back(mk(0,1,0,8'h22, 8'hA5,2,0,1));
        tbl.push_back(mk(0,1,0,8'h33, 8'hA5,3,0,1));
        tbl.push_back(mk(0,1,0,8'h44, 8'hA5,4,0,1));
        tbl.push_back(mk(0,1,0,8'h55, 8'hA5,4,1,1));
        tbl.push_back(mk(0,0,1,8'h00, 8'h11,3,1,1));
        tbl.push_back(mk(0,0,1,8'h00, 8'h22,2,1,1));
        tbl.push_back(mk(0,0,1,8'h00, 8'h33,1,1,1));
        tbl.push_back(mk(0,0,1,8'h00, 8'h44,0,1,1));
        tbl.push_back(mk(1,0,0,8'h00, 8'h44,0,0,0));
        tbl.push_back(mk(0,1,0,8'h11, 8'h44,1,0,0));
        tbl.push_back(mk(0,1,0,8'h22, 8'h44,2,0,0));
        tbl.push_back(mk(0,1,0,8'h33, 8'h44,3,0,0));
        tbl.push_back(mk(0,1,0,8'h44, 8'h44,4,0,0));
        tbl.push_back(mk(0,1,1,8'h66, 8'h11,4,0,0));
        tbl.push_back(mk(0,0,1,8'h00, 8'h22,3,0,0));
        tbl.push_back(mk(0,0,1,8'h00, 8'h33,2,0,0));
        tbl.push_back(mk(0,0,1,8'h00, 8'h44,1,0,0));
        tbl.push_back(mk(0,0,1,8'h00, 8'h66,0,0,0));
        tbl.push_back(mk(0,1,1,8'h77, 8'h66,1,0,1));
        tbl.push_back(mk(0,0,1,8'h00, 8'h77,0,0,1));
        tbl.push_back(mk(0,1,0,8'h88, 8'h77,1,0,1));
        tbl.push_back(mk(0,1,0,8'h99, 8'h77,2,0,1));
        tbl.push_back(mk(0,1,0,8'hAB, 8'h77,3,0,1));
        tbl.push_back(mk(0,1,0,8'hCD, 8'h77,4,0,1));
        tbl.push_back(mk(0,1,0,8'hEF, 8'h77,4,1,1));
        tbl.push_back(mk(1,1,1,8'h12, 8'h77,0,0,0));
        tbl.push_back(mk(0,0,1,8'h00, 8'h77,0,0,1));

        foreach (tbl[i]) begin
            step(tbl[i].clr, tbl[i].load, tbl[i].xfer, tbl[i].d);
            chk_all($sformatf("row%0d", i), tbl[i].q, tbl[i].cnt, tbl[i].ovf, tbl[i].udf);
        end

        // Async reset while entries are staged.
        step(0,1,0,8'hAA);
        step(0,1,0,8'hBB);
        chk("prerst COUNT", 32'(COUNT), 32'd2);
        pulse_reset();
        chk_all("asyncrst", 8'hA5, 0, 1'b0, 1'b0);
        release_reset();
        chk_all("postrst", 8'hA5, 0, 1'b0, 1'b0);

        // Randomized traffic against the queue model.
        mq.delete();
        m_q = 8'hA5; m_ovf = 1'b0; m_udf = 1'b0;
        for (int n = 0; n < 400; n++) begin
            c = ($urandom_range(0, 29) == 0);
            l = $urandom_range(0, 1) == 1;
            x = $urandom_range(0, 2) == 0;
            d = 8'($urandom);
            step(c, l, x, d);
            model_step(c, l, x, d);
            chk_all($sformatf("rnd%0d", n), m_q, mq.size(), m_ovf, m_udf);
        end

`ifdef DUTSIG_AUTO_XFER_EN
        pulse_reset();
        release_reset();
        PERIOD = 16'd3;
        step(0,1,0,8'h01);
        step(0,1,0,8'h02);
        step(0,1,0,8'h03);
        AUTO_EN = 1'b1;
        step(0,0,0,8'h00); chk("auto c1 Q", 32'(Q), 32'hA5);
        step(0,0,0,8'h00); chk("auto c2 Q", 32'(Q), 32'hA5);
        step(0,0,0,8'h00); chk("auto c3 Q", 32'(Q), 32'h01);
        chk("auto c3 COUNT", 32'(COUNT), 32'd2);
        step(0,0,0,8'h00); chk("auto c4 Q", 32'(Q), 32'h01);
        step(0,0,0,8'h00); chk("auto c5 Q", 32'(Q), 32'h01);
        step(0,0,1,8'h00); chk("auto coinc Q", 32'(Q), 32'h02);
        chk("auto coinc COUNT", 32'(COUNT), 32'd1);
        AUTO_EN = 1'b0;
        step(0,1,0,8'h04);
        step(0,1,0,8'h05);
        PERIOD  = 16'd0;
        AUTO_EN = 1'b1;
        step(0,0,0,8'h00); chk("p0 a Q", 32'(Q), 32'h03);
        step(0,0,0,8'h00); chk("p0 b Q", 32'(Q), 32'h04);
        step(0,0,0,8'h00); chk("p0 c Q", 32'(Q), 32'h05);
        step(0,0,0,8'h00); chk("p0 udf", 32'(UNDERFLOW), 32'd1);
        AUTO_EN = 1'b0;
        step(0,1,0,8'h06);
        step(0,0,0,8'h00);
        step(0,0,0,8'h00);
        chk("off Q", 32'(Q), 32'h05);
        chk("off COUNT", 32'(COUNT), 32'd1);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
